// File: rtl/mem_stage_if.sv
// Execute -> memory -> write-back handshake and payload bundle for mem_stage.
// master: the surrounding pipeline (execute, SRAM, write-back, decode); slave: mem_stage.
interface mem_stage_if #(
    parameter int MEM_OP_W = 3
);
    logic                ws_allowin;
    logic                ms_allowin;
    logic                es_to_ms_valid;
    logic [31:0]         es_pc;
    logic                es_rf_we;
    logic [4:0]          es_rf_waddr;
    logic [31:0]         es_alu_result;
    logic                es_res_from_mem;
    logic [MEM_OP_W-1:0] es_mem_op;
    logic [31:0]         data_sram_rdata;
    logic                ms_to_ws_valid;
    logic [31:0]         ms_pc;
    logic                ms_rf_we;
    logic [4:0]          ms_rf_waddr;
    logic [31:0]         ms_final_result;
    logic                ms_fwd_valid;
    logic [31:0]         ms_fwd_wdata;

    modport master (
        output ws_allowin, es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr,
               es_alu_result, es_res_from_mem, es_mem_op, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
               ms_final_result, ms_fwd_valid, ms_fwd_wdata
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr,
               es_alu_result, es_res_from_mem, es_mem_op, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr,
               ms_final_result, ms_fwd_valid, ms_fwd_wdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: captures SRAM load data, extracts/extends loads, selects writeback value.
// Optional decode bypass outputs are enabled by defining MS_FWD_EN.
module mem_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          MEM_OP_W = 3
) (
    input logic        clk,
    input logic        resetn,
    mem_stage_if.slave bus
);
    localparam logic [MEM_OP_W-1:0] OP_LB  = MEM_OP_W'(1);
    localparam logic [MEM_OP_W-1:0] OP_LH  = MEM_OP_W'(2);
    localparam logic [MEM_OP_W-1:0] OP_LBU = MEM_OP_W'(3);
    localparam logic [MEM_OP_W-1:0] OP_LHU = MEM_OP_W'(4);

    logic                ms_valid;
    logic                ms_first;
    logic [31:0]         ms_pc_r;
    logic                ms_rf_we_r;
    logic [4:0]          ms_rf_waddr_r;
    logic [31:0]         ms_alu_result_r;
    logic                ms_res_from_mem_r;
    logic [MEM_OP_W-1:0] ms_mem_op_r;
    logic [31:0]         rdata_buf;

    logic        ms_ready_go;
    logic        ms_allowin;
    logic        capture;
    logic [31:0] rdata;
    logic [1:0]  offset;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_ready_go = 1'b1;
    assign ms_allowin  = !ms_valid || (ms_ready_go && bus.ws_allowin);
    assign capture     = bus.es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid          <= 1'b0;
            ms_first          <= 1'b0;
            ms_pc_r           <= PC_RESET;
            ms_rf_we_r        <= 1'b0;
            ms_rf_waddr_r     <= 5'd0;
            ms_alu_result_r   <= 32'd0;
            ms_res_from_mem_r <= 1'b0;
            ms_mem_op_r       <= '0;
            rdata_buf         <= 32'd0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= bus.es_to_ms_valid;
            end
            if (capture) begin
                ms_pc_r           <= bus.es_pc;
                ms_rf_we_r        <= bus.es_rf_we;
                ms_rf_waddr_r     <= bus.es_rf_waddr;
                ms_alu_result_r   <= bus.es_alu_result;
                ms_res_from_mem_r <= bus.es_res_from_mem;
                ms_mem_op_r       <= bus.es_mem_op;
            end
            ms_first <= capture;
            // SRAM data is only valid in the first cycle; park it so stalls cannot lose it
            if (ms_first) begin
                rdata_buf <= bus.data_sram_rdata;
            end
        end
    end

    assign rdata  = ms_first ? bus.data_sram_rdata : rdata_buf;
    assign offset = ms_alu_result_r[1:0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Halfword access ignores offset[0]; misalignment is not trapped here
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (ms_mem_op_r)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

    assign final_result = ms_res_from_mem_r ? load_data : ms_alu_result_r;

    assign bus.ms_allowin      = ms_allowin;
    assign bus.ms_to_ws_valid  = ms_valid && ms_ready_go;
    assign bus.ms_pc           = ms_pc_r;
    assign bus.ms_rf_we        = ms_valid && ms_rf_we_r;
    assign bus.ms_rf_waddr     = ms_rf_waddr_r;
    assign bus.ms_final_result = final_result;

`ifdef MS_FWD_EN
    assign bus.ms_fwd_valid = ms_valid && ms_rf_we_r && (ms_rf_waddr_r != 5'd0);
    assign bus.ms_fwd_wdata = final_result;
`else
    // Ports kept so decode wiring does not change with the build option
    assign bus.ms_fwd_valid = 1'b0;
    assign bus.ms_fwd_wdata = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the instruction held in the stage.
module tb_mem_stage;
    localparam logic [31:0] PC_RST = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.MEM_OP_W(3)) bus();

    mem_stage #(.PC_RESET(PC_RST), .MEM_OP_W(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model of the instruction currently occupying the stage
    bit          m_valid;
    logic [31:0] m_pc;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_alu;
    logic        m_rfm;
    logic [2:0]  m_op;
    logic [31:0] m_rdata;

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] rd,
                                             input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = PC_RST;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_alu   = 32'd0;
        m_rfm   = 1'b0;
        m_op    = 3'd0;
        m_rdata = 32'd0;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] waddr, input logic [31:0] alu, input logic rfm,
                         input logic [2:0] op, input logic wsa);
        bus.es_to_ms_valid  = v;
        bus.es_pc           = pc;
        bus.es_rf_we        = we;
        bus.es_rf_waddr     = waddr;
        bus.es_alu_result   = alu;
        bus.es_res_from_mem = rfm;
        bus.es_mem_op       = op;
        bus.ws_allowin      = wsa;
    endtask

    task automatic check_all();
        logic [31:0] exp_final;
        exp_final = m_rfm ? ref_load(m_op, m_rdata, m_alu[1:0]) : m_alu;
        chk("to_ws_valid", {31'd0, bus.ms_to_ws_valid}, {31'd0, m_valid});
        chk("allowin", {31'd0, bus.ms_allowin}, {31'd0, (!m_valid || bus.ws_allowin)});
        chk("pc", bus.ms_pc, m_pc);
        chk("rf_we", {31'd0, bus.ms_rf_we}, {31'd0, (m_valid && m_we)});
        chk("rf_waddr", {27'd0, bus.ms_rf_waddr}, {27'd0, m_waddr});
        chk("final_result", bus.ms_final_result, exp_final);
`ifdef MS_FWD_EN
        chk("fwd_valid", {31'd0, bus.ms_fwd_valid}, {31'd0, (m_valid && m_we && m_waddr != 5'd0)});
        chk("fwd_wdata", bus.ms_fwd_wdata, exp_final);
`else
        chk("fwd_valid_off", {31'd0, bus.ms_fwd_valid}, 32'd0);
        chk("fwd_wdata_off", bus.ms_fwd_wdata, 32'd0);
`endif
    endtask

    // One clock: model follows the handshake, rd is what the SRAM shows in the following cycle
    task automatic advance(input logic [31:0] rd);
        logic        allow;
        logic        cap;
        logic        v;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic        rfm;
        logic [2:0]  op;
        allow = !m_valid || bus.ws_allowin;
        v     = bus.es_to_ms_valid;
        cap   = allow && v;
        pc    = bus.es_pc;
        we    = bus.es_rf_we;
        wa    = bus.es_rf_waddr;
        alu   = bus.es_alu_result;
        rfm   = bus.es_res_from_mem;
        op    = bus.es_mem_op;
        @(posedge clk);
        #1;
        if (allow) m_valid = v;
        if (cap) begin
            m_pc    = pc;
            m_we    = we;
            m_waddr = wa;
            m_alu   = alu;
            m_rfm   = rfm;
            m_op    = op;
            m_rdata = rd;
        end
        bus.data_sram_rdata = rd;
        #1;
        check_all();
    endtask

    initial begin
        logic [2:0]  ld_op [7];
        logic [1:0]  ld_off[7];
        logic [31:0] ld_exp[7];
        ld_op  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd2, 3'd4};
        ld_off = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
        ld_exp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                   32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};

        model_reset();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 1'b1);
        bus.data_sram_rdata = 32'h5555_AAAA;
        #12;
        chk("reset_pc", bus.ms_pc, PC_RST);
        chk("reset_valid", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        chk("reset_allowin", {31'd0, bus.ms_allowin}, 32'd1);
        chk("reset_final", bus.ms_final_result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // ALU passthrough
        drive(1'b1, 32'h0000_0040, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 1'b1);
        advance(32'hFFFF_0000);
        chk("alu_final", bus.ms_final_result, 32'h1234_5678);
        chk("alu_rf_we", {31'd0, bus.ms_rf_we}, 32'd1);
        chk("alu_waddr", {27'd0, bus.ms_rf_waddr}, 32'd5);

        // Load extraction table
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 5'd3, 32'h1000 + {30'd0, ld_off[i]},
                  1'b1, ld_op[i], 1'b1);
            advance(32'h80FF_7F01);
            chk($sformatf("load_%0d", i), bus.ms_final_result, ld_exp[i]);
        end

        // Stall hold while SRAM output changes
        drive(1'b1, 32'h0000_0200, 1'b1, 5'd9, 32'h0000_2000, 1'b1, 3'd0, 1'b1);
        advance(32'hDEAD_BEEF);
        drive(1'b1, 32'h0000_0204, 1'b1, 5'd10, 32'h0000_2004, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            advance(32'h0000_0000);
            chk("stall_final", bus.ms_final_result, 32'hDEAD_BEEF);
            chk("stall_allowin", {31'd0, bus.ms_allowin}, 32'd0);
            chk("stall_pc", bus.ms_pc, 32'h0000_0200);
        end
        bus.ws_allowin = 1'b1;
        advance(32'h0000_0000);
        chk("drain_pc", bus.ms_pc, 32'h0000_0204);

        // Back-to-back then bubble
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h40 + 32'(i), 1'b0, 3'd0, 1'b1);
            advance($urandom);
            chk("b2b_pc", bus.ms_pc, 32'h100 + 32'(4 * i));
            chk("b2b_valid", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        end
        drive(1'b0, 32'h0000_0999, 1'b1, 5'd4, 32'h0, 1'b0, 3'd0, 1'b1);
        advance($urandom);
        chk("bubble_valid", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        chk("bubble_rf_we", {31'd0, bus.ms_rf_we}, 32'd0);

        // Forwarding outputs
        drive(1'b1, 32'h0000_0500, 1'b1, 5'd0, 32'h0000_0077, 1'b0, 3'd0, 1'b1);
        advance($urandom);
        chk("fwd_zero_reg", {31'd0, bus.ms_fwd_valid}, 32'd0);
        drive(1'b1, 32'h0000_0504, 1'b1, 5'd7, 32'h0000_3000, 1'b1, 3'd0, 1'b1);
        advance(32'hCAFE_F00D);
`ifdef MS_FWD_EN
        chk("fwd_load_valid", {31'd0, bus.ms_fwd_valid}, 32'd1);
        chk("fwd_load_wdata", bus.ms_fwd_wdata, 32'hCAFE_F00D);
`else
        chk("fwd_load_valid_off", {31'd0, bus.ms_fwd_valid}, 32'd0);
        chk("fwd_load_wdata_off", bus.ms_fwd_wdata, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 5'($urandom),
                  $urandom, 1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0));
            advance($urandom);
        end

        // Asynchronous reset while a stalled instruction is held
        drive(1'b1, 32'h0000_0700, 1'b1, 5'd12, 32'h0000_0123, 1'b0, 3'd0, 1'b0);
        advance($urandom);
        advance($urandom);
        chk("pre_reset_valid", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        chk("async_rst_rf_we", {31'd0, bus.ms_rf_we}, 32'd0);
        chk("async_rst_pc", bus.ms_pc, PC_RST);
        chk("async_rst_allowin", {31'd0, bus.ms_allowin}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 32'h0000_0800, 1'b1, 5'd6, 32'h0000_0456, 1'b0, 3'd0, 1'b1);
        advance($urandom);
        chk("post_reset_pc", bus.ms_pc, 32'h0000_0800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of write-back.
- Accepts one instruction per handshake from execute.
- Captures the synchronous data-SRAM read data that returns one cycle after execute issued the access, and holds it across write-back stalls.
- Performs byte/halfword load extraction with sign/zero extension, selects the final writeback value, and exposes destination info to decode for hazard detection.

Parameters:
- PC_RESET, 32'h0000_0000, reset value of ms_pc.
- MEM_OP_W, 3, width of load-type code.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- ws_allowin  in  1  write-back can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute presents an instruction
- es_pc  in  32  instruction PC
- es_rf_we  in  1  writes register file
- es_rf_waddr  in  5  destination register
- es_alu_result  in  32  ALU result / memory address
- es_res_from_mem  in  1  instruction is a load
- es_mem_op  in  MEM_OP_W  load type
- data_sram_rdata  in  32  SRAM read data, valid the cycle after the access
- ms_to_ws_valid  out  1  instruction ready for write-back
- ms_pc  out  32  instruction PC
- ms_rf_we  out  1  gated write enable (to write-back and decode)
- ms_rf_waddr  out  5  destination register
- ms_final_result  out  32  writeback value
- ms_fwd_valid  out  1  forwarding valid (optional feature)
- ms_fwd_wdata  out  32  forwarding data (optional feature)

Reset and clocking (decided):
- One clock, clk.
- resetn is asynchronous and active-low; all registers clear immediately on resetn=0.

Behaviour:
- Reset values: ms_valid=0, ms_pc=PC_RESET, all other payload registers, rdata_buf and ms_first = 0.
- Resulting outputs in reset: ms_to_ws_valid=0, ms_rf_we=0, ms_final_result=0, ms_allowin=1.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Valid bit: on a clk edge with ms_allowin=1, ms_valid <= es_to_ms_valid.
- Payload capture:
  - Payload (pc, rf_we, rf_waddr, alu_result, res_from_mem, mem_op) loads only when es_to_ms_valid && ms_allowin.
  - Otherwise the payload holds.
- First-cycle tracking:
  - ms_first <= 1 on payload capture, else 0.
  - While ms_first=1, rdata_buf <= data_sram_rdata.
  - Effective rdata = ms_first ? data_sram_rdata : rdata_buf.
  - Data therefore survives any number of ws_allowin=0 cycles, even if the SRAM output changes.
- Load extraction, offset = ms_alu_result[1:0]:
  - 000 LW: rdata.
  - 001 LB: byte[offset], sign-extended.
  - 010 LH: half[offset[1]], sign-extended.
  - 011 LBU: byte[offset], zero-extended.
  - 100 LHU: half[offset[1]], zero-extended.
  - 101–111: treated as LW.
  - Misaligned halfword (offset[0]=1): offset[0] is ignored; no exception is raised.
- ms_final_result = ms_res_from_mem ? load_data : ms_alu_result. Purely combinational from the registers; zero extra latency.
- ms_rf_we output = ms_valid && ms_rf_we_reg. A bubble never reports a write.
- Latency: one cycle from execute handshake to ms_to_ws_valid.
- Stall: with ws_allowin=0 and ms_valid=1, ms_allowin=0 and all outputs are held stable.
- Bubble: es_to_ms_valid=0 with ms_allowin=1 clears ms_valid; the payload is held but masked.
- Simultaneous drain and fill: when ws takes the current instruction and es presents a new one in the same cycle, the new instruction is captured with no bubble.
- Reset mid-stall: ms_valid drops asynchronously and the held instruction is discarded.

Optional Feature:
- Macro MS_FWD_EN.
- Defined:
  - ms_fwd_valid = ms_valid && ms_rf_we_reg && (ms_rf_waddr != 0).
  - ms_fwd_wdata = ms_final_result.
  - Decode uses these to bypass, including load results.
- Undefined:
  - ms_fwd_valid=0 and ms_fwd_wdata=0, constant.
  - Ports stay present so decode wiring is unchanged.

Test Plan:
- Reset: assert resetn=0 asynchronously mid-cycle with ms_valid=1 -> ms_to_ws_valid=0, ms_rf_we=0 and ms_pc=PC_RESET before the next edge; ms_allowin=1.
- ALU passthrough: es_alu_result=32'h1234_5678, es_res_from_mem=0, rf_we=1, waddr=5 -> one cycle later ms_final_result=32'h1234_5678, ms_rf_we=1, ms_rf_waddr=5.
- Load extraction: rdata=32'h80FF_7F01 at addr offsets 0..3:
  - LB -> 32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80.
  - LBU offset 3 -> 32'h0000_0080.
  - LH offset 2 -> 32'hFFFF_80FF.
  - LHU offset 0 -> 32'h0000_7F01.
- Stall hold: LW with rdata=32'hDEAD_BEEF, then ws_allowin=0 for 3 cycles while rdata changes to 32'h0 -> ms_final_result stays 32'hDEAD_BEEF; ms_allowin=0 for all 3 cycles.
- Back-to-back: es_to_ms_valid=1 and ws_allowin=1 for 4 consecutive cycles with PCs 0x100/0x104/0x108/0x10C -> ms_pc follows one cycle behind with no bubbles. Then a bubble cycle -> ms_to_ws_valid=0, ms_rf_we=0.
- MS_FWD_EN: waddr=0, rf_we=1 -> ms_fwd_valid=0. waddr=7, LW rdata=32'hCAFE_F00D -> ms_fwd_valid=1, ms_fwd_wdata=32'hCAFE_F00D. Without the macro both outputs stay 0.
